// File: rtl/branch_cond_unit.sv
// branch_cond_unit: NZCV flag register, CBZ/CBNZ/B.cond resolution and taken-branch counter
module branch_cond_unit #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             ex_valid_i,
  input  logic             set_flags_i,
  input  logic             alu_n_i,
  input  logic             alu_z_i,
  input  logic             alu_c_i,
  input  logic             alu_v_i,
  input  logic             br_valid_i,
  input  logic [1:0]       br_type_i,
  input  logic [3:0]       cond_i,
  input  logic             rt_zero_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic [3:0]       flags_o,
  output logic             br_done_o,
  output logic             br_taken_o,
  output logic [CNT_W-1:0] taken_cnt_o
);
  typedef enum logic {IDLE, RESOLVED} state_e;
  state_e           state_q, state_d;
  logic [3:0]       flags_q, flags_d, eff;
  logic             taken_q, taken_d, cond_hit, dec, wr_flags;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign wr_flags = ex_valid_i & set_flags_i;
  // flags seen by this cycle's branch: freshly produced ones win over the register
  always_comb begin
    eff = wr_flags ? {alu_n_i, alu_z_i, alu_c_i, alu_v_i} : flags_q;
    cond_hit = 1'b1;
    case (cond_i)
      4'b0000: cond_hit = eff[2];
      4'b0001: cond_hit = !eff[2];
      4'b0010: cond_hit = eff[1];
      4'b0011: cond_hit = !eff[1];
      4'b0100: cond_hit = eff[3];
      4'b0101: cond_hit = !eff[3];
      4'b0110: cond_hit = eff[0];
      4'b0111: cond_hit = !eff[0];
      4'b1000: cond_hit = eff[1] & !eff[2];
      4'b1001: cond_hit = !eff[1] | eff[2];
      4'b1010: cond_hit = eff[3] == eff[0];
      4'b1011: cond_hit = eff[3] != eff[0];
      4'b1100: cond_hit = !eff[2] & (eff[3] == eff[0]);
      4'b1101: cond_hit = eff[2] | (eff[3] != eff[0]);
      default: cond_hit = 1'b1;
    endcase
    dec = br_type_i == 2'b00 ? 1'b1 :
          br_type_i == 2'b01 ? rt_zero_i :
          br_type_i == 2'b10 ? !rt_zero_i : cond_hit;
  end
  // next state: stall freezes everything, flush drops any branch, otherwise a new branch resolves
  always_comb begin
    state_d = state_q;
    taken_d = taken_q;
    if (!stall_i) begin
      state_d = (!flush_i && br_valid_i) ? RESOLVED : IDLE;
      taken_d = (!flush_i && br_valid_i) ? dec : taken_q;
    end
    flags_d = (wr_flags && !stall_i) ? {alu_n_i, alu_z_i, alu_c_i, alu_v_i} : flags_q;
    cnt_d = (!stall_i && br_done_o && taken_q && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
  end
  // state registers with asynchronous clear
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      taken_q <= 1'b0;
      flags_q <= 4'b0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      taken_q <= taken_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end
  assign br_done_o   = (state_q == RESOLVED) && !flush_i;
  assign br_taken_o  = taken_q;
  assign flags_o     = flags_q;
  assign taken_cnt_o = cnt_q;
endmodule

// File: tb/tb_branch_cond_unit.sv
// tb_branch_cond_unit: directed vectors checked against a behavioural flag/branch model
module tb_branch_cond_unit;
  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 0, rst_n = 1;
  logic ev = 0, sf = 0, bv = 0, rz = 0, st = 0, fl = 0;
  logic [3:0] nzcv = 0, cd = 0;
  logic [1:0] bt = 0;
  logic [3:0] flags;
  logic done, taken;
  logic [CW-1:0] cnt;
  int vectors = 0, errors = 0;
  bit chk = 0;
  logic [3:0] m_flags = 0;
  bit m_pend = 0, m_taken = 0;
  int m_cnt = 0;

  branch_cond_unit #(.CNT_W(CW)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .ex_valid_i(ev), .set_flags_i(sf),
    .alu_n_i(nzcv[3]), .alu_z_i(nzcv[2]), .alu_c_i(nzcv[1]), .alu_v_i(nzcv[0]),
    .br_valid_i(bv), .br_type_i(bt), .cond_i(cd), .rt_zero_i(rz),
    .stall_i(st), .flush_i(fl), .flags_o(flags), .br_done_o(done),
    .br_taken_o(taken), .taken_cnt_o(cnt));

  always #5 clk = ~clk;

  // ARM condition semantics: the even code tests a base predicate, the odd code negates it
  function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = n == v;
      3'd6: base = !z && n == v;
      default: base = 1;
    endcase
    return c[3:1] == 3'd7 ? 1'b1 : base ^ c[0];
  endfunction

  function automatic bit decide(input logic [1:0] t, input logic r, input logic [3:0] c, input logic [3:0] f);
    if (t == 2'b00) return 1'b1;
    if (t == 2'b01) return r;
    if (t == 2'b10) return !r;
    return cond_true(c, f);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_flags <= 0; m_pend <= 0; m_taken <= 0; m_cnt <= 0;
    end else if (!st) begin
      if (ev && sf) m_flags <= nzcv;
      if (m_pend && !fl && m_taken) m_cnt <= (m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1;
      m_pend <= bv && !fl;
      if (bv && !fl) m_taken <= decide(bt, rz, cd, (ev && sf) ? nzcv : m_flags);
    end
  end

  task automatic ck(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk) begin
    ck("m_flags", flags, m_flags);
    ck("m_done", done, m_pend && !fl);
    if (m_pend && !fl) ck("m_taken", taken, m_taken);
    ck("m_cnt", cnt, m_cnt);
  end

  task automatic go(input logic b, input logic [1:0] t, input logic [3:0] c, input logic r,
                    input logic e, input logic s, input logic [3:0] f, input logic stl, input logic flu);
    bv = b; bt = t; cd = c; rz = r; ev = e; sf = s; nzcv = f; st = stl; fl = flu;
    @(posedge clk); #1;
    bv = 0; bt = 0; cd = 0; rz = 0; ev = 0; sf = 0; nzcv = 0; st = 0; fl = 0;
  endtask

  task automatic br(input logic [1:0] t, input logic [3:0] c, input logic r);
    go(1, t, c, r, 0, 0, 0, 0, 0);
  endtask

  task automatic setf(input logic [3:0] f);
    go(0, 0, 0, 0, 1, 1, f, 0, 0);
  endtask

  initial begin
    #2 rst_n = 0;
    chk = 1;
    for (int i = 0; i < 4; i++)
      go($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    ck("rst_flags", flags, 0); ck("rst_done", done, 0); ck("rst_cnt", cnt, 0);
    rst_n = 1;
    br(2'b11, 4'b0000, 0);
    ck("eq_done", done, 1); ck("eq_taken", taken, 0);
    go(1, 2'b11, 4'b0000, 0, 1, 1, 4'b0100, 0, 0);
    ck("byp_taken", taken, 1); ck("byp_flags", flags, 4'b0100);
    setf(4'b1000);
    br(2'b11, 4'b1011, 0); ck("lt", taken, 1);
    br(2'b11, 4'b1010, 0); ck("ge", taken, 0);
    br(2'b11, 4'b1100, 0); ck("gt0", taken, 0);
    br(2'b11, 4'b1101, 0); ck("le", taken, 1);
    setf(4'b1001);
    br(2'b11, 4'b1100, 0); ck("gt1", taken, 1);
    br(2'b01, 0, 1); ck("cbz1", taken, 1);
    br(2'b10, 0, 1); ck("cbnz1", taken, 0);
    br(2'b01, 0, 0); ck("cbz0", taken, 0);
    br(2'b10, 0, 0); ck("cbnz0", taken, 1);
    ck("cb_flags", flags, 4'b1001);
    br(2'b00, 0, 0);
    rst_n = 0; #1;
    ck("async_done", done, 0); ck("async_flags", flags, 0); ck("async_cnt", cnt, 0);
    @(posedge clk); #1 rst_n = 1;
    br(2'b00, 0, 0);
    ck("st_done0", done, 1); ck("st_cnt0", cnt, 0);
    for (int i = 0; i < 3; i++) begin
      go(0, 0, 0, 0, 0, 0, 0, 1, 0);
      ck("st_done", done, 1); ck("st_cnt", cnt, 0);
    end
    go(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ck("st_after_done", done, 0); ck("st_after_cnt", cnt, 1);
    br(2'b00, 0, 0);
    fl = 1; #1;
    ck("fl_done", done, 0);
    @(posedge clk); #1 fl = 0;
    ck("fl_done_after", done, 0); ck("fl_cnt", cnt, 1);
    go(1, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    ck("flbr_done", done, 0);
    go(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ck("flbr_cnt", cnt, 1);
    for (int i = 0; i < 20; i++) begin
      br(2'b11, 4'b1110, 0);
      ck("al_done", done, 1);
    end
    go(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ck("sat_cnt", cnt, 15);
    br(2'b11, 4'b1111, 0); ck("nv", taken, 1);
    go(0, 0, 0, 0, 1, 1, 4'b1111, 1, 0);
    ck("st_flags", flags, 0);
    foreach (nzcv[i]) ;
    for (int p = 0; p < 6; p++) begin
      logic [3:0] pats [6];
      pats = '{4'b0000, 4'b0100, 4'b1001, 4'b0011, 4'b1010, 4'b0110};
      for (int c = 0; c < 16; c++) go(1, 2'b11, c[3:0], 0, 1, 1, pats[p], 0, 0);
      setf(pats[p]);
      for (int c = 0; c < 16; c++) br(2'b11, c[3:0], 0);
    end
    go(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

Consumer side of the ALU flag path in the 64-bit ARM pipeline. Captures the N/Z/C/V flags produced by the EX stage (Z comes from the 64-bit zero detector) into an architectural flag register. Evaluates CBZ/CBNZ and B.cond decisions against those flags with a same-cycle bypass. Returns a registered taken/not-taken decision to the fetch/PC logic, and keeps a saturating taken-branch counter for debug.

## Interface
Parameters:
- CNT_W, 8, width of the saturating taken-branch counter.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset; clears all state immediately.
- ex_valid  in  1  EX stage holds a real instruction this cycle.
- set_flags  in  1  instruction is flag-setting (ADDS/SUBS); qualified by ex_valid.
- alu_n, alu_z, alu_c, alu_v  in  1 each  flags from the current ALU result.
- br_valid  in  1  branch instruction presented for evaluation this cycle.
- br_type  in  2  00 unconditional B, 01 CBZ, 10 CBNZ, 11 B.cond.
- cond  in  4  ARM condition code; used only when br_type=11.
- rt_zero  in  1  zero-detector output for the CBZ/CBNZ source register.
- stall  in  1  pipeline hold; freezes all state.
- flush  in  1  kill the branch in flight and suppress its output.
- flags_q  out  4  architectural {N,Z,C,V}.
- br_done  out  1  one-cycle pulse: a decision is available.
- br_taken  out  1  the decision; meaningful only when br_done=1.
- taken_cnt  out  CNT_W  saturating count of taken branches.

## Operation
- Flag register: when ex_valid & set_flags & !stall, flags_q <= {alu_n,alu_z,alu_c,alu_v} at the clock edge. Otherwise flags_q holds.
- Effective flags for evaluation (eff): the incoming ALU flags when ex_valid & set_flags is true in the same cycle; otherwise flags_q. This bypass makes B.cond directly after SUBS see the new flags.
- Decision (combinational, then registered):
  - br_type 00 -> taken.
  - br_type 01 -> rt_zero.
  - br_type 10 -> !rt_zero.
  - br_type 11 -> condition table on eff.
- Condition table:
  - EQ 0000 Z; NE 0001 !Z.
  - HS 0010 C; LO 0011 !C.
  - MI 0100 N; PL 0101 !N.
  - VS 0110 V; VC 0111 !V.
  - HI 1000 C&!Z; LS 1001 !C|Z.
  - GE 1010 N==V; LT 1011 N!=V.
  - GT 1100 !Z&(N==V); LE 1101 Z|(N!=V).
  - AL 1110 1; NV 1111 1 (ARMv8 semantics).
- Two-state FSM: IDLE and RESOLVED.
  - IDLE -> RESOLVED on br_valid & !flush & !stall; the decision is registered into br_taken.
  - RESOLVED -> IDLE on the next unstalled cycle; if br_valid is asserted again, stay in RESOLVED with the new decision, so back-to-back branches are allowed.
  - flush in RESOLVED -> IDLE, and br_done is forced to 0 that cycle.
- br_done = (state==RESOLVED) & !flush. Outputs hold while stall=1.
- taken_cnt increments when br_done & br_taken and saturates at 2^CNT_W-1; it never wraps.
- Reset values: flags_q=0000, state=IDLE, br_done=0, br_taken=0, taken_cnt=0.

## Timing
- Flag write latency: 1 cycle. The bypass gives 0-cycle visibility to a branch in the same cycle.
- Decision latency: br_valid at cycle t -> br_done/br_taken at cycle t+1.
- stall wins over every input: no flag write, no FSM transition, no counter change.
- flush at the same edge as br_valid: that branch is dropped and no br_done follows.
- reset_n low mid-operation: all outputs return to reset values asynchronously. The first decision is possible one cycle after reset_n deasserts with br_valid high.
- A set_flags instruction and a branch in the same cycle update flags_q and evaluate with the same new flags.

## Test plan
- Reset: hold reset_n=0 with random inputs -> flags_q=0, br_done=0, taken_cnt=0. Release, then send B.cond EQ -> br_done=1, br_taken=0 next cycle.
- Bypass: set_flags=1 with alu_z=1 and B.cond EQ in the same cycle -> br_taken=1 at t+1 and flags_q=0100 at t+1.
- Signed conditions: flags_q N=1,V=0 -> LT taken, GE not taken, GT not taken, LE taken. Flags N=1,V=1,Z=0 -> GT taken.
- CBZ/CBNZ: rt_zero=1 -> CBZ taken, CBNZ not taken. rt_zero=0 -> the opposite. flags_q is unchanged in both cases.
- Stall/flush: br_valid followed by stall for 3 cycles -> br_done stays high across the stall, with one count increment. br_valid with flush at t+1 -> br_done=0 and taken_cnt unchanged.
- Saturation: CNT_W=4, 20 back-to-back AL branches -> br_done high every cycle and taken_cnt stops at 15.
